// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer controller.
package timer_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A run is only meaningful with a non-zero terminal count.
  function automatic logic valid_limit(input logic [31:0] lim);
    return (lim != 32'd0);
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle between a control source and timer_ctrl.
interface timer_ctrl_if #(
  parameter int N = 8,
  parameter int P = 4
);
  logic         start;
  logic         stop;
  logic         periodic;
  logic [N-1:0] load_val;
  logic [P-1:0] prescale;
  logic [N-1:0] cnt;
  logic         tick;
  logic         busy;
  logic         done;

  // Control source side.
  modport master (
    output start, stop, periodic, load_val, prescale,
    input  cnt, tick, busy, done
  );

  // Timer side.
  modport slave (
    input  start, stop, periodic, load_val, prescale,
    output cnt, tick, busy, done
  );
endinterface

// File: rtl/timer_ctrl_prescaler.sv
// Step-rate divider: asserts en once every limit+1 clocks while run is high.
module prescaler #(
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         run,
  input  logic [P-1:0] limit,
  output logic         en
);

  logic [P-1:0] presc_q;
  logic [P-1:0] presc_d;

  assign en = run && (presc_q == limit);

  // Divider count: wraps to 0 on each step, parked at 0 when not running.
  always_comb begin
    presc_d = presc_q;
    if (clear || !run || en) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: start/run/terminate sequencing of an up-counter
// with prescaled step rate, one-shot or periodic reload, and tick pulse.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int N = 8,
  parameter int P = 4
) (
  input  logic         clock,
  input  logic         reset,
  timer_ctrl_if.slave  bus
);

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;
  logic [N-1:0] lim_q, lim_d;
  logic [P-1:0] psc_q, psc_d;
  logic         per_q, per_d;
  logic         en;
  logic         presc_clr;
  logic         start_ok;

  // A start is only honoured with a non-zero terminal count.
  assign start_ok = bus.start && valid_limit(32'(bus.load_val));

  // Keep the divider at 0 whenever the next state is not RUN, so every run
  // begins with a full p+1 clock interval before the first step.
  assign presc_clr = (state_d != RUN);

  prescaler #(.P(P)) u_presc (
    .clk   (clock),
    .rst   (reset),
    .clear (presc_clr),
    .run   (state_q == RUN),
    .limit (psc_q),
    .en    (en)
  );

  // Next-state and datapath decode; stop always wins over start and terminal.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    lim_d   = lim_q;
    psc_d   = psc_q;
    per_d   = per_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus.stop && start_ok) begin
          state_d = RUN;
          lim_d   = bus.load_val;
          psc_d   = bus.prescale;
          per_d   = bus.periodic;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt_q == lim_q) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            state_d = per_q ? RUN : DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        cnt_d = '0;
        if (bus.stop) begin
          state_d = IDLE;
        end else if (start_ok) begin
          state_d = RUN;
          lim_d   = bus.load_val;
          psc_d   = bus.prescale;
          per_d   = bus.periodic;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, count and capture registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      lim_q   <= '0;
      psc_q   <= '0;
      per_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      lim_q   <= lim_d;
      psc_q   <= psc_d;
      per_q   <= per_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tick = tick_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: an 8-bit instance for the main scenarios
// and a 2-bit instance for the full-range reload and reset-mid-run case.
module tb_timer_ctrl;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  timer_ctrl_if #(.N(8), .P(4)) b8 ();
  timer_ctrl_if #(.N(2), .P(4)) b2 ();

  timer_ctrl #(.N(8), .P(4)) u8 (.clock(clock), .reset(rst), .bus(b8));
  timer_ctrl #(.N(2), .P(4)) u2 (.clock(clock), .reset(rst), .bus(b2));

  typedef struct {
    int         d;
    logic [7:0] c;
    logic       t;
    logic       b;
    logic       dn;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;

  // Wait for the next edge, queue what the outputs must be after it, then
  // drop single-cycle requests so each caller sets only what it needs.
  task automatic tk(input int d, input int c, input logic t, input logic b, input logic dn);
    exp_t e;
    @(posedge clock);
    e.d = d; e.c = 8'(c); e.t = t; e.b = b; e.dn = dn; e.tag = tag;
    sb.push_back(e);
    #1;
    rst = 1'b0;
    b8.start = 1'b0; b8.stop = 1'b0;
    b2.start = 1'b0; b2.stop = 1'b0;
  endtask

  always @(negedge clock) begin : monitor
    exp_t       e;
    logic [7:0] ac;
    logic       at, ab, ad;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.d == 0) begin
        ac = b8.cnt; at = b8.tick; ab = b8.busy; ad = b8.done;
      end else begin
        ac = {6'b0, b2.cnt}; at = b2.tick; ab = b2.busy; ad = b2.done;
      end
      checks++;
      if ({ac, at, ab, ad} !== {e.c, e.t, e.b, e.dn}) begin
        errors++;
        $display("FAIL s%0d cnt/tick/busy/done got %0d/%b/%b/%b want %0d/%b/%b/%b at %0t",
                 e.tag, ac, at, ab, ad, e.c, e.t, e.b, e.dn, $time);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    b8.start = 0; b8.stop = 0; b8.periodic = 0; b8.load_val = 0; b8.prescale = 0;
    b2.start = 0; b2.stop = 0; b2.periodic = 0; b2.load_val = 0; b2.prescale = 0;

    // s1: reset, then start with zero limit is ignored
    tag = 1;
    rst = 1; tk(0, 0, 0, 0, 0);
    rst = 1; tk(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      b8.start = 1; b8.load_val = 0;
      tk(0, 0, 0, 0, 0);
    end

    // s2: one-shot, p=0, L=3
    tag = 2;
    b8.start = 1; b8.load_val = 3; b8.prescale = 0; b8.periodic = 0;
    tk(0, 0, 0, 1, 0);
    tk(0, 1, 0, 1, 0);
    tk(0, 2, 0, 1, 0);
    tk(0, 3, 0, 1, 0);
    tk(0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) tk(0, 0, 0, 0, 1);
    b8.stop = 1; tk(0, 0, 0, 0, 0);

    // s3: periodic, p=2, L=1; start during RUN must be ignored
    tag = 3;
    b8.start = 1; b8.load_val = 1; b8.prescale = 2; b8.periodic = 1;
    tk(0, 0, 0, 1, 0);
    for (int r = 0; r < 3; r++) begin
      if (r == 1) begin
        b8.start = 1; b8.load_val = 5; b8.prescale = 0; b8.periodic = 0;
      end
      tk(0, 0, 0, 1, 0);
      tk(0, 0, 0, 1, 0);
      tk(0, 1, 0, 1, 0);
      tk(0, 1, 0, 1, 0);
      tk(0, 1, 0, 1, 0);
      tk(0, 0, 1, 1, 0);
    end
    b8.stop = 1; tk(0, 0, 0, 0, 0);

    // s4: stop mid-run at cnt=5, idle, then full one-shot L=10
    tag = 4;
    b8.start = 1; b8.load_val = 10; b8.prescale = 0; b8.periodic = 0;
    tk(0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) tk(0, i, 0, 1, 0);
    b8.stop = 1; tk(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tk(0, 0, 0, 0, 0);
    b8.start = 1; b8.load_val = 10;
    tk(0, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) tk(0, i, 0, 1, 0);
    tk(0, 0, 1, 0, 1);
    b8.stop = 1; tk(0, 0, 0, 0, 0);

    // s5: stop collides with terminal count; start+stop together in IDLE
    tag = 5;
    b8.start = 1; b8.load_val = 2; b8.prescale = 0; b8.periodic = 0;
    tk(0, 0, 0, 1, 0);
    tk(0, 1, 0, 1, 0);
    tk(0, 2, 0, 1, 0);
    b8.stop = 1; tk(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tk(0, 0, 0, 0, 0);
    b8.start = 1; b8.stop = 1; b8.load_val = 5;
    tk(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tk(0, 0, 0, 0, 0);

    // s6: N=2, L=3 periodic p=0, then reset at cnt=2
    tag = 6;
    b2.start = 1; b2.load_val = 2'd3; b2.prescale = 0; b2.periodic = 1;
    tk(1, 0, 0, 1, 0);
    tk(1, 1, 0, 1, 0);
    tk(1, 2, 0, 1, 0);
    tk(1, 3, 0, 1, 0);
    tk(1, 0, 1, 1, 0);
    tk(1, 1, 0, 1, 0);
    tk(1, 2, 0, 1, 0);
    rst = 1; tk(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tk(1, 0, 0, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
